// File: rtl/video_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_ctrl_if
// Brief    : Pixel-source valid/ready handshake between upstream and scan-out.
// Revision : 1.0
// ============================================================================
interface video_timing_ctrl_if;
    logic       pix_valid;
    logic [3:0] pix_data;
    logic       pix_ready;

    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_ctrl
// Brief    : Line/frame scan-out scheduler driving the 4-bit video DAC.
// Revision : 1.0
// ============================================================================
module video_timing_ctrl #(
    parameter int unsigned H_TOTAL        = 1016,
    parameter int unsigned H_SYNC         = 75,
    parameter int unsigned H_BACK         = 120,
    parameter int unsigned H_ACTIVE       = 800,
    parameter int unsigned V_TOTAL        = 262,
    parameter int unsigned V_SYNC         = 3,
    parameter int unsigned V_ACTIVE_START = 20,
    parameter int unsigned V_ACTIVE       = 240,
    parameter logic [3:0]  SYNC_LEVEL     = 4'd0,
    parameter logic [3:0]  BLANK_LEVEL    = 4'd3,
    parameter logic [3:0]  BLACK_LEVEL    = 4'd4
) (
    input  wire logic                clk,
    input  wire logic                NRST,
    input  wire logic                pll_lock,
    input  wire logic                enable,
    video_timing_ctrl_if.slave       pix,
    output      logic [3:0]          vdac_out,
    output      logic                vdac_oe,
    output      logic                line_start,
    output      logic                frame_start,
    output      logic                underrun,
    input  wire logic                underrun_clr
);

    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] c_h_last       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] c_h_back_start = HW'(H_SYNC);
    localparam logic [HW-1:0] c_h_act_start  = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] c_h_front_start= HW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [HW-1:0] c_h_broad_end  = HW'(H_TOTAL - H_SYNC);
    localparam logic [VW-1:0] c_v_last       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] c_v_sync_end   = VW'(V_SYNC);
    // One spare bit so an active window ending exactly at V_TOTAL still compares.
    localparam logic [VW:0]   c_v_act_start  = (VW+1)'(V_ACTIVE_START);
    localparam logic [VW:0]   c_v_act_end    = (VW+1)'(V_ACTIVE_START + V_ACTIVE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HSYNC  = 3'd1,
        ST_BACK   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FRONT  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic            stop_req_q, stop_req_d;
    logic            pix_ready_q, pix_ready_d;
    logic            line_start_q, line_start_d;
    logic            frame_start_q, frame_start_d;
    logic [3:0]      vdac_out_q, vdac_out_d;
    logic            vdac_oe_q, vdac_oe_d;
    logic            underrun_q, underrun_d;

    logic            w_frame_end;
    logic [3:0]      w_pix_clamped;

    function automatic state_t phase_of(input logic [HW-1:0] h);
        if (h < c_h_back_start)       return ST_HSYNC;
        else if (h < c_h_act_start)   return ST_BACK;
        else if (h < c_h_front_start) return ST_ACTIVE;
        else                          return ST_FRONT;
    endfunction

    function automatic logic line_active(input logic [VW-1:0] v);
        return ({1'b0, v} >= c_v_act_start) && ({1'b0, v} < c_v_act_end);
    endfunction

    assign w_frame_end   = (h_q == c_h_last) && (v_q == c_v_last);
    assign w_pix_clamped = (pix.pix_data > BLACK_LEVEL) ? pix.pix_data : BLACK_LEVEL;

    // Timing front end: next position, phase and the per-position strobes.
    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        stop_req_d    = stop_req_q;
        pix_ready_d   = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (state_q == ST_IDLE) begin
            h_d        = '0;
            v_d        = '0;
            stop_req_d = 1'b0;
            if (pll_lock && enable) begin
                state_d       = ST_HSYNC;
                line_start_d  = 1'b1;
                frame_start_d = 1'b1;
            end
        end else if (!pll_lock || (w_frame_end && (stop_req_q || !enable))) begin
            state_d    = ST_IDLE;
            h_d        = '0;
            v_d        = '0;
            stop_req_d = 1'b0;
        end else begin
            // A stop request is latched so re-enabling mid-frame cannot cancel it.
            stop_req_d = stop_req_q || !enable;
            if (h_q == c_h_last) begin
                h_d = '0;
                v_d = (v_q == c_v_last) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            state_d       = phase_of(h_d);
            line_start_d  = (h_d == '0);
            frame_start_d = (h_d == '0) && (v_d == '0);
            pix_ready_d   = (state_d == ST_ACTIVE) && line_active(v_d);
        end
    end

    // Output stage: level for the current position, visible one cycle later.
    always_comb begin
        vdac_out_d = BLANK_LEVEL;
        vdac_oe_d  = 1'b0;
        underrun_d = (pix_ready_q && !pix.pix_valid) || (underrun_q && !underrun_clr);

        if ((state_q != ST_IDLE) && pll_lock) begin
            vdac_oe_d = 1'b1;
            if (v_q < c_v_sync_end) begin
                vdac_out_d = (h_q < c_h_broad_end) ? SYNC_LEVEL : BLANK_LEVEL;
            end else begin
                case (state_q)
                    ST_HSYNC:  vdac_out_d = SYNC_LEVEL;
                    ST_ACTIVE: begin
                        if (pix_ready_q) begin
                            vdac_out_d = pix.pix_valid ? w_pix_clamped : BLACK_LEVEL;
                        end
                    end
                    default:   vdac_out_d = BLANK_LEVEL;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            state_q       <= ST_IDLE;
            h_q           <= '0;
            v_q           <= '0;
            stop_req_q    <= 1'b0;
            pix_ready_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vdac_out_q    <= BLANK_LEVEL;
            vdac_oe_q     <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            stop_req_q    <= stop_req_d;
            pix_ready_q   <= pix_ready_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vdac_out_q    <= vdac_out_d;
            vdac_oe_q     <= vdac_oe_d;
            underrun_q    <= underrun_d;
        end
    end

    assign pix.pix_ready = pix_ready_q;
    assign line_start    = line_start_q;
    assign frame_start   = frame_start_q;
    assign vdac_out      = vdac_out_q;
    assign vdac_oe       = vdac_oe_q;
    assign underrun      = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_ctrl
// Brief    : Directed scoreboard bench for video_timing_ctrl with small timing.
// Revision : 1.0
// ============================================================================
module tb_video_timing_ctrl;

    logic       clk;
    logic       NRST;
    logic       pll_lock;
    logic       enable;
    logic       underrun_clr;
    logic [3:0] vdac_out;
    logic       vdac_oe;
    logic       line_start;
    logic       frame_start;
    logic       underrun;

    int         checks;
    int         errors;
    int         k;
    logic       ur_exp;
    logic [3:0] exp_q[$];

    video_timing_ctrl_if pix_bus ();

    video_timing_ctrl #(
        .H_TOTAL        (16),
        .H_SYNC         (2),
        .H_BACK         (3),
        .H_ACTIVE       (8),
        .V_TOTAL        (6),
        .V_SYNC         (1),
        .V_ACTIVE_START (2),
        .V_ACTIVE       (3)
    ) dut (
        .clk          (clk),
        .NRST         (NRST),
        .pll_lock     (pll_lock),
        .enable       (enable),
        .pix          (pix_bus),
        .vdac_out     (vdac_out),
        .vdac_oe      (vdac_oe),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference level for a running position, straight from the line/frame layout.
    function automatic logic [3:0] level(input int h, input int v,
                                         input logic valid, input logic [3:0] d);
        if (v < 1)  return (h < 14) ? 4'd0 : 4'd3;
        if (h < 2)  return 4'd0;
        if (h < 5)  return 4'd3;
        if (h < 13) begin
            if (v >= 2 && v < 5) return !valid ? 4'd4 : ((d < 4'd4) ? 4'd4 : d);
            return 4'd3;
        end
        return 4'd3;
    endfunction

    // One running cycle at position k: check strobes, queue the level, advance.
    task automatic step();
        int         h;
        int         v;
        logic       rdy;
        logic [3:0] e;
        h   = k % 16;
        v   = (k / 16) % 6;
        rdy = (h >= 5) && (h < 13) && (v >= 2) && (v < 5);
        chk("frame_start", {7'd0, frame_start}, {7'd0, (k % 96) == 0});
        chk("line_start",  {7'd0, line_start},  {7'd0, h == 0});
        chk("pix_ready",   {7'd0, pix_bus.pix_ready}, {7'd0, rdy});
        exp_q.push_back(level(h, v, pix_bus.pix_valid, pix_bus.pix_data));
        ur_exp = (rdy && !pix_bus.pix_valid) || (ur_exp && !underrun_clr);
        tick();
        k++;
        e = exp_q.pop_front();
        chk("vdac_out", {4'd0, vdac_out}, {4'd0, e});
        chk("vdac_oe",  {7'd0, vdac_oe},  8'd1);
        chk("underrun", {7'd0, underrun}, {7'd0, ur_exp});
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_vdac_out"},    {4'd0, vdac_out},          8'd3);
        chk({tag, "_vdac_oe"},     {7'd0, vdac_oe},           8'd0);
        chk({tag, "_pix_ready"},   {7'd0, pix_bus.pix_ready}, 8'd0);
        chk({tag, "_line_start"},  {7'd0, line_start},        8'd0);
        chk({tag, "_frame_start"}, {7'd0, frame_start},       8'd0);
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        k                 = 0;
        ur_exp            = 1'b0;
        NRST              = 1'b0;
        pll_lock          = 1'b0;
        enable            = 1'b0;
        underrun_clr      = 1'b0;
        pix_bus.pix_valid = 1'b0;
        pix_bus.pix_data  = 4'd0;

        tick();
        tick();
        chk_idle_outputs("reset");
        chk("reset_underrun", {7'd0, underrun}, 8'd0);
        NRST = 1'b1;
        tick();
        tick();
        chk_idle_outputs("idle_nolock");

        // Lock alone must not start scan-out.
        pll_lock = 1'b1;
        tick();
        chk_idle_outputs("idle_noenable");

        pix_bus.pix_valid = 1'b1;
        pix_bus.pix_data  = 4'd9;
        enable            = 1'b1;
        tick();
        k = 0;
        chk("first_vdac_out", {4'd0, vdac_out}, 8'd3);
        chk("first_vdac_oe",  {7'd0, vdac_oe},  8'd0);

        // Frame 1: constant pixel 9.
        while (k < 96) begin
            pix_bus.pix_valid = 1'b1;
            pix_bus.pix_data  = 4'd9;
            step();
        end

        // Frame 2: varied data (clamps), underruns and clears.
        while (k < 192) begin
            pix_bus.pix_valid = !((k == 135) || (k == 165));
            pix_bus.pix_data  = 4'((k * 3) % 16);
            underrun_clr      = (k == 150) || (k == 165) || (k == 170);
            step();
        end
        underrun_clr = 1'b0;

        // Frame 3: enable dropped at v=3, frame must still complete.
        while (k < 288) begin
            if (k == 240) enable = 1'b0;
            pix_bus.pix_valid = 1'b1;
            pix_bus.pix_data  = 4'd9;
            step();
        end
        chk("stop_frame_start", {7'd0, frame_start},       8'd0);
        chk("stop_line_start",  {7'd0, line_start},        8'd0);
        chk("stop_pix_ready",   {7'd0, pix_bus.pix_ready}, 8'd0);
        tick();
        chk_idle_outputs("stopped");
        tick();
        chk_idle_outputs("stopped_hold");

        // Restart, then lose lock at h=7, v=2.
        enable = 1'b1;
        tick();
        k = 0;
        chk("restart_frame_start", {7'd0, frame_start}, 8'd1);
        chk("restart_line_start",  {7'd0, line_start},  8'd1);
        chk("restart_vdac_oe",     {7'd0, vdac_oe},     8'd0);
        while (k < 39) step();
        chk("prelock_pix_ready", {7'd0, pix_bus.pix_ready}, 8'd1);
        pll_lock = 1'b0;
        tick();
        chk_idle_outputs("lockloss");
        tick();
        chk_idle_outputs("lockloss_hold");

        // Relock restarts from the top of the frame.
        pll_lock = 1'b1;
        tick();
        k = 0;
        chk("relock_frame_start", {7'd0, frame_start}, 8'd1);
        chk("relock_line_start",  {7'd0, line_start},  8'd1);
        chk("relock_vdac_out",    {4'd0, vdac_out},    8'd3);
        while (k < 38) begin
            pix_bus.pix_valid = (k != 37);
            step();
        end
        pix_bus.pix_valid = 1'b1;
        chk("prereset_pix_ready", {7'd0, pix_bus.pix_ready}, 8'd1);
        chk("prereset_underrun",  {7'd0, underrun},          8'd1);

        // Asynchronous reset between clock edges.
        #2;
        NRST = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        chk("async_reset_underrun", {7'd0, underrun}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
